fixed_ln: RTL and testbench



---
 rtl/fixed_pkg.sv | 15 +
 rtl/fixed_ln_if.sv | 22 ++
 rtl/fixed_lod.sv | 20 ++
 rtl/fixed_ln.sv | 129 ++++++++++++
 tb/tb_fixed_ln.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fixed_pkg.sv
// Shared Q16.16 sign-magnitude fixed-point definitions.
// Word geometry, constants and the ln FSM state type.
package fixed_pkg;
  localparam int N = 32;
  localparam int Q = 16;
  localparam logic [N-1:0] LN2_Q16 = 32'h0000_B172;
  localparam logic [N-1:0] ONE_Q16 = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    FRAC,
    SCALE
  } ln_state_t;
endpackage

// File: rtl/fixed_ln_if.sv
// Start/done request bundle for the sequential ln unit.
// The caller drives start/x; the unit returns busy/done/result/err.
interface fixed_ln_if;
  import fixed_pkg::*;

  logic         start;
  logic [N-1:0] x;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         err;

  modport master (
    output start, x,
    input  busy, done, result, err
  );

  modport slave (
    input  start, x,
    output busy, done, result, err
  );
endinterface

// File: rtl/fixed_lod.sv
// Leading-one detector over a sign-magnitude magnitude field.
// Reports the highest set bit position and an all-zero flag.
module fixed_lod
  import fixed_pkg::*;
(
  input  logic [N-2:0] mag_i,
  output logic [4:0]   pos_o,
  output logic         zero_o
);

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < N-1; i++) begin
      if (mag_i[i]) pos_o = 5'(i);
    end
  end

  assign zero_o = ~|mag_i;

endmodule

// File: rtl/fixed_ln.sv
// Sequential ln(x) for Q16.16 sign-magnitude operands.
// Normalise, square-iterate one log2 bit per cycle, then scale by ln2.
module fixed_ln
  import fixed_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  fixed_ln_if.slave  bus
);

  ln_state_t        state_q, state_d;
  logic [N-1:0]     x_q, x_d;
  logic [N-1:0]     m_q, m_d;
  logic [5:0]       e_q, e_d;
  logic [Q-1:0]     frac_q, frac_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N-1:0]     res_q, res_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [4:0]       pos;
  logic             zero;
  logic [63:0]      sq;
  logic signed [N-1:0] l_val;
  logic [N-1:0]     l_abs;
  logic [47:0]      prod;
  logic [N-2:0]     mag;
  logic             unused_bits;

  fixed_lod u_lod (
    .mag_i  (x_q[N-2:0]),
    .pos_o  (pos),
    .zero_o (zero)
  );

  assign sq    = {32'b0, m_q} * {32'b0, m_q};
  assign l_val = {{10{e_q[5]}}, e_q, 16'b0} + {16'b0, frac_q};
  assign l_abs = l_val[N-1] ? N'(-l_val) : N'(l_val);
  assign prod  = {16'b0, l_abs} * {32'b0, LN2_Q16[15:0]};
  assign mag   = prod[46:16];
  assign unused_bits = ^{sq[63], sq[29:0], prod[47], prod[15:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      m_q     <= '0;
      e_q     <= '0;
      frac_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      m_q     <= m_d;
      e_q     <= e_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = NORM;
      NORM:    state_d = (zero || x_q[N-1]) ? IDLE : FRAC;
      FRAC:    if (cnt_q == 4'(Q-1)) state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    m_d    = m_q;
    e_d    = e_q;
    frac_d = frac_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    err_d  = err_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) x_d = bus.x;
      end
      NORM: begin
        if (zero) begin
          res_d  = 32'hFFFF_FFFF;
          err_d  = 1'b1;
          done_d = 1'b1;
        end else if (x_q[N-1]) begin
          res_d  = '0;
          err_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          e_d    = {1'b0, pos} - 6'd16;
          m_d    = {1'b0, x_q[N-2:0]} << (5'd30 - pos);
          cnt_d  = '0;
          frac_d = '0;
        end
      end
      FRAC: begin
        // s >= 2 means this log2 bit is set; renormalise m into [1,2)
        frac_d = {frac_q[Q-2:0], sq[61]};
        m_d    = sq[61] ? sq[62:31] : sq[61:30];
        cnt_d  = cnt_q + 4'd1;
      end
      SCALE: begin
        res_d  = {l_val[N-1] && (mag != '0), mag};
        err_d  = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy   = (state_q != IDLE);
    bus.done   = done_q;
    bus.result = res_q;
    bus.err    = err_q;
  end

endmodule

// File: tb/tb_fixed_ln.sv
// Directed scoreboard bench for fixed_ln.
// Expectations are queued at acceptance and matched on each done.
module tb_fixed_ln;
  import fixed_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          tol;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  fixed_ln_if bus ();

  fixed_ln dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int sm2i(logic [31:0] v);
    int m;
    m = int'({1'b0, v[30:0]});
    return v[31] ? -m : m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(string tag, logic [31:0] obs,
                         logic [31:0] exp, int tol);
    int d;
    checks++;
    d = sm2i(obs) - sm2i(exp);
    assert (obs[31] === exp[31] && d <= tol && d >= -tol) else begin
      errors++;
      $error("FAIL %s got %h want %h tol %0d", tag, obs, exp, tol);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("err", 32'(bus.err), 32'(e.err));
        if (e.tol == 0) chk("result", bus.result, e.res);
        else chk_tol("result_tol", bus.result, e.res, e.tol);
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic push(logic [31:0] xv, logic [31:0] r, logic e, int tol);
    exp_t it;
    it.res = r;
    it.err = e;
    it.tol = tol;
    it.lat = e ? 1 : 18;
    it.acc = cyc + 1;
    sb.push_back(it);
    bus.x     = xv;
    bus.start = 1'b1;
  endtask

  task automatic req(logic [31:0] xv, logic [31:0] r, logic e, int tol);
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    chk("req_idle", 32'(bus.busy), 32'd0);
    push(xv, r, e, tol);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = 32'h1234_5678;
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    req(32'h0001_0000, 32'h0000_0000, 1'b0, 0); drain(40);
    req(32'h0002_0000, 32'h0000_B172, 1'b0, 0); drain(40);
    req(32'h0000_8000, 32'h8000_B172, 1'b0, 0); drain(40);
    req(32'h0000_0001, 32'h800B_1720, 1'b0, 0); drain(40);
    req(32'h0002_B7E1, 32'h0001_0000, 1'b0, 2); drain(40);
    req(32'h0004_0000, 32'h0001_62E4, 1'b0, 0); drain(40);
    req(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0); drain(10);
    req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0); drain(10);
    req(32'h8001_0000, 32'h0000_0000, 1'b1, 0); drain(10);

    // start held high; x scrambled while busy must not be re-latched
    n = 0;
    for (int g = 0; g < 300 && n < 6; g++) begin
      if (!bus.busy) begin
        if (n[0]) push(32'h0000_8000, 32'h8000_B172, 1'b0, 0);
        else push(32'h0002_0000, 32'h0000_B172, 1'b0, 0);
        n++;
      end else begin
        bus.x = $urandom;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("b2b_accepts", 32'(n), 32'd6);
    drain(60);

    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    bus.x     = 32'h0004_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_err", 32'(bus.err), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);

    req(32'h0004_0000, 32'h0001_62E4, 1'b0, 0); drain(40);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
